exu_stage: RTL

- Registered, handshaked RV32I execute stage. Sits between the IDU and the LSU/WBU.
- Accepts one decoded instruction per valid/ready transfer. Computes the ALU result, next PC, and memory address/data. Presents them on a one-entry output register.
- Successor to the single-opcode, free-running EXU. Adds:
  - full OP/OP-IMM/LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE coverage;
  - a backpressure handshake;
  - a parametrised width;
  - an optional area-saving serial shifter.

---
 rtl/exu_if.sv | 60 ++++++
 rtl/exu_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_if.sv
// ---------------------------------------------------------------------------
// exu_if: bundle between the decode stage, the execute stage and the
// memory/writeback side.
//
// Handshake: a transfer happens on a rising cpu_clk edge where valid and
// ready are both high. While valid is high and ready is low, the sender
// keeps valid and every payload signal stable. ready may depend
// combinationally on the receiver's state and on downstream ready.
//
//   in_*       decoded instruction, IDU -> EXU (in_ready flows back)
//   out_*      execute result, EXU -> LSU/WBU (out_ready flows back)
//   dbg_state  execute-stage FSM state, observation only
//
// modport slave  : the execute stage
// modport master : the surrounding pipeline (or a testbench)
// ---------------------------------------------------------------------------
interface exu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7_5;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [4:0]      in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_npc;
    logic [XLEN-1:0] out_mem_addr;
    logic [XLEN-1:0] out_mem_wdata;
    logic            out_load;
    logic            out_store;
    logic [2:0]      out_funct3;
    logic            out_illegal;
    logic [1:0]      dbg_state;

    modport slave (
        input  in_valid, in_pc, in_imm, in_opcode, in_funct3, in_funct7_5,
               in_rs1_data, in_rs2_data, in_rd, out_ready,
        output in_ready, out_valid, out_rd, out_wen, out_result, out_npc,
               out_mem_addr, out_mem_wdata, out_load, out_store, out_funct3,
               out_illegal, dbg_state
    );

    modport master (
        output in_valid, in_pc, in_imm, in_opcode, in_funct3, in_funct7_5,
               in_rs1_data, in_rs2_data, in_rd, out_ready,
        input  in_ready, out_valid, out_rd, out_wen, out_result, out_npc,
               out_mem_addr, out_mem_wdata, out_load, out_store, out_funct3,
               out_illegal, dbg_state
    );
endinterface

// File: rtl/exu_stage.sv
// ---------------------------------------------------------------------------
// exu_stage: registered, handshaked RV32I execute stage.
//
// Takes one decoded instruction per in_valid/in_ready transfer, computes
// the ALU result, next PC and memory address/data, and presents them in a
// one-entry output register (out_valid = result held).
//
// Ports:
//   cpu_clk  clock, rising edge
//   rst      asynchronous reset, active-high; clears every output register
//   bus      exu_if.slave: in_* instruction side, out_* result side,
//            dbg_state exposes the FSM state (IDLE/SHIFT/HOLD)
//
// Parameters:
//   XLEN          datapath width (32 for RV32I)
//   SERIAL_SHIFT  0: barrel shifter; 1: one bit per cycle in state SHIFT
//   SHAMT_W       shift-amount width, log2(XLEN)
// ---------------------------------------------------------------------------
module exu_stage #(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 0,
    parameter int SHAMT_W      = 5
) (
    input  logic cpu_clk,
    input  logic rst,
    exu_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;

    logic [XLEN-1:0]    r_result, r_npc, r_addr, r_wdata;
    logic [4:0]         r_rd;
    logic [2:0]         r_funct3;
    logic               r_wen, r_load, r_store, r_illegal;
    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] count;
    logic               sh_left, sh_arith;

    logic [XLEN-1:0] pc, imm, rs1, rs2, op_b, sum, alu;
    logic [XLEN-1:0] pc4, pc_imm, rs1_imm, acc_step;
    logic [XLEN-1:0] nx_result, nx_npc, nx_addr, nx_wdata;
    logic [SHAMT_W-1:0] shamt;
    logic [2:0] f3;
    logic is_op, is_op_imm, illegal, taken, writes, nx_load, nx_store, nx_wen;
    logic is_shift, serial_go, in_ready_w, accept;

    assign pc  = bus.in_pc;
    assign imm = bus.in_imm;
    assign rs1 = bus.in_rs1_data;
    assign rs2 = bus.in_rs2_data;
    assign f3  = bus.in_funct3;

    // ready while empty, or while the held result leaves this very cycle
    assign in_ready_w = (state == IDLE) || (state == HOLD && bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;

    // one serial step; SRA shifts the sign bit back in
    assign acc_step = sh_left ? {acc[XLEN-2:0], 1'b0}
                              : {sh_arith & acc[XLEN-1], acc[XLEN-1:1]};

    always_comb begin
        is_op     = (bus.in_opcode == OPC_OP);
        is_op_imm = (bus.in_opcode == OPC_OP_IMM);
        op_b      = is_op ? rs2 : imm;
        shamt     = op_b[SHAMT_W-1:0];
        sum       = (is_op && bus.in_funct7_5 && f3 == 3'b000) ? rs1 - op_b : rs1 + op_b;
        pc4       = pc + XLEN'(4);
        pc_imm    = pc + imm;
        rs1_imm   = rs1 + imm;

        case (f3)
            3'b000:  alu = sum;
            3'b001:  alu = rs1 << shamt;
            3'b010:  alu = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(op_b)};
            3'b011:  alu = {{(XLEN-1){1'b0}}, rs1 < op_b};
            3'b100:  alu = rs1 ^ op_b;
            3'b101:  alu = bus.in_funct7_5 ? XLEN'($signed(rs1) >>> shamt) : (rs1 >> shamt);
            3'b110:  alu = rs1 | op_b;
            default: alu = rs1 & op_b;
        endcase

        case (f3)
            3'b000:  taken = (rs1 == rs2);
            3'b001:  taken = (rs1 != rs2);
            3'b100:  taken = ($signed(rs1) <  $signed(rs2));
            3'b101:  taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  taken = (rs1 <  rs2);
            3'b111:  taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase

        case (bus.in_opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                illegal = 1'b0;
            OPC_BRANCH: illegal = (f3 == 3'b010) || (f3 == 3'b011);
            OPC_LOAD:   illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            OPC_STORE:  illegal = (f3 > 3'b010);
            default:    illegal = 1'b1;
        endcase

        nx_result = '0;
        nx_npc    = pc4;
        nx_addr   = '0;
        nx_wdata  = '0;
        nx_load   = 1'b0;
        nx_store  = 1'b0;
        writes    = 1'b0;
        if (!illegal) begin
            case (bus.in_opcode)
                OPC_OP, OPC_OP_IMM: begin nx_result = alu;    writes = 1'b1; end
                OPC_LUI:            begin nx_result = imm;    writes = 1'b1; end
                OPC_AUIPC:          begin nx_result = pc_imm; writes = 1'b1; end
                OPC_JAL: begin
                    nx_result = pc4;
                    nx_npc    = pc_imm;
                    writes    = 1'b1;
                end
                OPC_JALR: begin
                    nx_result = pc4;
                    nx_npc    = {rs1_imm[XLEN-1:1], 1'b0};
                    writes    = 1'b1;
                end
                OPC_BRANCH: if (taken) nx_npc = pc_imm;
                OPC_LOAD: begin
                    nx_load = 1'b1;
                    nx_addr = rs1_imm;
                    writes  = 1'b1;
                end
                OPC_STORE: begin
                    nx_store = 1'b1;
                    nx_addr  = rs1_imm;
                    nx_wdata = rs2;
                end
                default: ;
            endcase
        end
        nx_wen    = writes && (bus.in_rd != 5'd0);
        is_shift  = (is_op || is_op_imm) && (f3 == 3'b001 || f3 == 3'b101);
        serial_go = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r_result  <= '0;
            r_npc     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_funct3  <= '0;
            r_wen     <= 1'b0;
            r_load    <= 1'b0;
            r_store   <= 1'b0;
            r_illegal <= 1'b0;
            acc       <= '0;
            count     <= '0;
            sh_left   <= 1'b0;
            sh_arith  <= 1'b0;
        end else if (state == SHIFT) begin
            if (count == SHAMT_W'(1)) begin
                r_result <= acc_step;
                state    <= HOLD;
            end else begin
                acc   <= acc_step;
                count <= count - SHAMT_W'(1);
            end
        end else if (accept) begin
            // everything but a multi-cycle shift result is final here
            r_result  <= nx_result;
            r_npc     <= nx_npc;
            r_addr    <= nx_addr;
            r_wdata   <= nx_wdata;
            r_rd      <= bus.in_rd;
            r_funct3  <= f3;
            r_wen     <= nx_wen;
            r_load    <= nx_load;
            r_store   <= nx_store;
            r_illegal <= illegal;
            if (serial_go) begin
                acc      <= rs1;
                count    <= shamt;
                sh_left  <= (f3 == 3'b001);
                sh_arith <= bus.in_funct7_5;
                state    <= SHIFT;
            end else begin
                state <= HOLD;
            end
        end else if (state == HOLD && bus.out_ready) begin
            state <= IDLE;
        end
    end

    assign bus.in_ready      = in_ready_w;
    assign bus.out_valid     = (state == HOLD);
    assign bus.out_rd        = r_rd;
    assign bus.out_wen       = r_wen;
    assign bus.out_result    = r_result;
    assign bus.out_npc       = r_npc;
    assign bus.out_mem_addr  = r_addr;
    assign bus.out_mem_wdata = r_wdata;
    assign bus.out_load      = r_load;
    assign bus.out_store     = r_store;
    assign bus.out_funct3    = r_funct3;
    assign bus.out_illegal   = r_illegal;
    assign bus.dbg_state     = state;
endmodule
